m_match_classifier: RTL and testbench
=====================================

Name: m_match_classifier

Overview:
- Parametrised successor to the fixed four-way symbol-match front end.
- Holds N runtime-programmable match rules, each with a word offset, match value, bit mask and buffer id.
- Watches the ingress packet stream, records which rules hit within each packet, and issues one classification result per packet at EOP.
- Adds masked compare, per-rule enable, configurable rule count, a default buffer and a backpressured result port; none of these existed before.

Parameters:
- N_RULES, 4, number of match rules (1..16)
- W_DATA, 64, data word width
- W_OFF, 8, packet word-offset width
- W_BUF, 4, buffer id width
- DEFAULT_BUF, 0, buffer id reported when no rule hits

Ports:
- clk_net  in  1  clock
- rst_net  in  1  asynchronous active-low reset
- cfg_vld  in  1  rule write strobe
- cfg_idx  in  $clog2(N_RULES)  rule index to write
- cfg_en  in  1  rule enable
- cfg_off  in  W_OFF  word offset to compare
- cfg_match  in  W_DATA  match value
- cfg_mask  in  W_DATA  compare mask (1 = bit compared)
- cfg_buffer  in  W_BUF  buffer id for rule
- in_vld  in  1  ingress beat valid
- in_sop  in  1  first beat of packet
- in_eop  in  1  last beat of packet
- in_data  in  W_DATA  ingress word
- res_vld  out  1  result valid
- res_rdy  in  1  result accepted
- res_hit  out  N_RULES  per-rule hit vector for packet
- res_buffer  out  W_BUF  selected buffer id
- err_ovf  out  1  sticky: result dropped
- err_proto  out  1  sticky: SOP/EOP protocol violation

Behaviour:
- Reset (rst_net low, async): all rules disabled with fields 0; off_r=0; in_pkt_r=0; hit_r=0; res_vld=0; res_hit=0; res_buffer=0; err_ovf=0; err_proto=0.
- Config: when cfg_vld is high, rule[cfg_idx] is written at the clock edge and is used from the next beat. A write mid-packet affects only later beats; hits already recorded are kept.
- Offset tracking:
  - A SOP beat is offset 0; off_r becomes 1 after it.
  - Each non-SOP beat in a packet uses off_r, then increments it.
  - off_r saturates at 2^W_OFF-1 and sets off_sat_r. While off_sat_r is set, no rule can hit.
- Beat hit for rule i: in_vld & in_pkt_or_sop & en_i & ~off_sat & (cur_off==off_i) & (((in_data ^ match_i) & mask_i) == 0). A mask of 0 matches any word at that offset.
- Hit accumulation:
  - hit_r is sticky for the packet.
  - A SOP beat loads hit_r with that beat's hits, discarding prior state.
  - The final vector is hit_r | beat_hit, or beat_hit alone for a single-beat packet (SOP and EOP together).
- Result:
  - Appears the cycle after the EOP beat (latency 1).
  - res_hit is the final vector.
  - res_buffer is the buffer of the lowest-index set bit, or DEFAULT_BUF when the vector is zero.
  - res_vld holds with stable data until res_vld & res_rdy.
  - If res_rdy is high in the same cycle a new EOP completes, the new result loads with no bubble.
- Overflow: an EOP completes while res_vld & ~res_rdy → new result discarded, old result held, err_ovf=1 (sticky until reset).
- Protocol errors (set err_proto, sticky):
  - Beat without SOP while not in a packet → beat ignored.
  - SOP while in a packet → old packet abandoned with no result; the new packet starts normally.
- in_pkt_r is set by a SOP beat without EOP and cleared by an EOP beat.
- No ingress backpressure; every beat is consumed.

Decomposition:
- Add to m_pkg: default width localparams, and a parametrised-width rule-configuration struct convention (en, off, match, mask, buffer).
- Sub-module m_match_rule: one rule. It holds the config register, the masked compare and the sticky hit bit, and is instantiated N_RULES times via generate.
- Priority select (lowest index wins) and result/handshake logic stay in the top level.

Test Plan:
- Rule0 = {en, off 2, match 0xAB, mask 0xFF}, buffer 3; 4-beat packet with word2 = 0x12AB → res_hit=0001, res_buffer=3, res_vld 1 cycle after EOP.
- Rule1 (buf 5) and rule2 (buf 7) both hit the same packet → res_hit=0110, res_buffer=5; no rule hits → res_hit=0, res_buffer=DEFAULT_BUF.
- Single-beat packet (SOP+EOP) hitting rule at off 0 → result next cycle; the following packet starts with a clean hit vector.
- res_rdy held low across two packets → first result held unchanged, second dropped, err_ovf=1; res_rdy high at the next EOP cycle → back-to-back results with no bubble.
- Beat without SOP when idle → err_proto=1, no result. SOP mid-packet → err_proto=1, only the second packet's result issued.
- Packet longer than 2^W_OFF words with rule off = max → no hit after saturation. Async reset asserted mid-packet → all outputs 0 immediately and rules disabled.

Source files
------------

// File: rtl/m_pkg.sv
// Shared definitions for the match classifier.
// Holds the default widths used by the classifier and its rule sub-module,
// the reference layout of a rule configuration record, and a helper that
// sizes the rule index so a single-rule build still gets a 1-bit index.
package m_pkg;

  localparam int unsigned N_RULES_DEF     = 4;
  localparam int unsigned W_DATA_DEF      = 64;
  localparam int unsigned W_OFF_DEF       = 8;
  localparam int unsigned W_BUF_DEF       = 4;
  localparam int unsigned DEFAULT_BUF_DEF = 0;

  // Reference rule layout at default widths. Modules built with other widths
  // declare a local struct with exactly these fields in this order.
  typedef struct packed {
    logic                  en;
    logic [W_OFF_DEF-1:0]  off;
    logic [W_DATA_DEF-1:0] match;
    logic [W_DATA_DEF-1:0] mask;
    logic [W_BUF_DEF-1:0]  buffer;
  } rule_cfg_def_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/m_match_rule.sv
// One match rule: configuration register, masked word compare at a fixed
// packet offset, and the per-packet sticky hit bit.
// Ports:
//   clk_net, rst_net      clock, async active-low reset
//   cfg_we                write strobe for this rule (index already decoded)
//   cfg_en..cfg_buffer    new rule fields
//   beat_acc              a beat is being consumed this cycle
//   in_sop                the consumed beat starts a packet
//   cur_off, off_sat      offset of the current beat and its saturation flag
//   in_data               ingress word
//   hit                   packet hit including this beat (meaningful on EOP)
//   buffer                buffer id programmed for this rule
module m_match_rule
  import m_pkg::*;
#(
  parameter int unsigned W_DATA = W_DATA_DEF,
  parameter int unsigned W_OFF  = W_OFF_DEF,
  parameter int unsigned W_BUF  = W_BUF_DEF
) (
  input  logic              clk_net,
  input  logic              rst_net,
  input  logic              cfg_we,
  input  logic              cfg_en,
  input  logic [W_OFF-1:0]  cfg_off,
  input  logic [W_DATA-1:0] cfg_match,
  input  logic [W_DATA-1:0] cfg_mask,
  input  logic [W_BUF-1:0]  cfg_buffer,
  input  logic              beat_acc,
  input  logic              in_sop,
  input  logic [W_OFF-1:0]  cur_off,
  input  logic              off_sat,
  input  logic [W_DATA-1:0] in_data,
  output logic              hit,
  output logic [W_BUF-1:0]  buffer
);

  typedef struct packed {
    logic              en;
    logic [W_OFF-1:0]  off;
    logic [W_DATA-1:0] match;
    logic [W_DATA-1:0] mask;
    logic [W_BUF-1:0]  buffer;
  } rule_cfg_t;

  rule_cfg_t cfg_r;
  logic      hit_r;
  logic      beat_hit;

  assign beat_hit = beat_acc & cfg_r.en & ~off_sat & (cur_off == cfg_r.off) &
                    (((in_data ^ cfg_r.match) & cfg_r.mask) == '0);

  // A SOP beat starts a fresh packet, so earlier hits are not carried in.
  assign hit    = in_sop ? beat_hit : (hit_r | beat_hit);
  assign buffer = cfg_r.buffer;

  always_ff @(posedge clk_net or negedge rst_net) begin
    if (!rst_net) begin
      cfg_r <= '0;
      hit_r <= 1'b0;
    end else begin
      if (cfg_we) begin
        cfg_r.en     <= cfg_en;
        cfg_r.off    <= cfg_off;
        cfg_r.match  <= cfg_match;
        cfg_r.mask   <= cfg_mask;
        cfg_r.buffer <= cfg_buffer;
      end
      if (beat_acc) hit_r <= hit;
    end
  end

endmodule

// File: rtl/m_match_classifier.sv
// Packet match classifier: N programmable rules watch the ingress stream,
// hits are accumulated per packet and one result is issued after each EOP.
// Ports:
//   clk_net, rst_net               clock, async active-low reset
//   cfg_vld, cfg_idx, cfg_*        rule write port
//   in_vld, in_sop, in_eop, in_data  ingress beats (no backpressure)
//   res_vld, res_rdy               result handshake
//   res_hit, res_buffer            per-rule hit vector, selected buffer id
//   err_ovf                        sticky: a result was dropped
//   err_proto                      sticky: SOP/EOP framing violation
module m_match_classifier
  import m_pkg::*;
#(
  parameter int unsigned N_RULES     = N_RULES_DEF,
  parameter int unsigned W_DATA      = W_DATA_DEF,
  parameter int unsigned W_OFF       = W_OFF_DEF,
  parameter int unsigned W_BUF       = W_BUF_DEF,
  parameter int unsigned DEFAULT_BUF = DEFAULT_BUF_DEF,
  localparam int unsigned W_IDX      = idx_width(N_RULES)
) (
  input  logic               clk_net,
  input  logic               rst_net,
  input  logic               cfg_vld,
  input  logic [W_IDX-1:0]   cfg_idx,
  input  logic               cfg_en,
  input  logic [W_OFF-1:0]   cfg_off,
  input  logic [W_DATA-1:0]  cfg_match,
  input  logic [W_DATA-1:0]  cfg_mask,
  input  logic [W_BUF-1:0]   cfg_buffer,
  input  logic               in_vld,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [W_DATA-1:0]  in_data,
  output logic               res_vld,
  input  logic               res_rdy,
  output logic [N_RULES-1:0] res_hit,
  output logic [W_BUF-1:0]   res_buffer,
  output logic               err_ovf,
  output logic               err_proto
);

  localparam logic [W_OFF-1:0] OFF_MAX = {W_OFF{1'b1}};

  logic               in_pkt_r;
  logic [W_OFF-1:0]   off_r;
  logic               off_sat_r;
  logic               beat_acc;
  logic               beat_bad;
  logic               eop_done;
  logic [W_OFF-1:0]   cur_off;
  logic               cur_sat;
  logic [N_RULES-1:0] fin_hit;
  logic [W_BUF-1:0]   rule_buf [N_RULES];
  logic [W_BUF-1:0]   sel_buf;

  // Beats outside a packet are only accepted if they open one.
  assign beat_acc = in_vld & (in_sop | in_pkt_r);
  assign beat_bad = in_vld & (in_sop ? in_pkt_r : ~in_pkt_r);
  assign eop_done = beat_acc & in_eop;
  assign cur_off  = in_sop ? '0 : off_r;
  assign cur_sat  = in_sop ? 1'b0 : off_sat_r;

  for (genvar i = 0; i < N_RULES; i++) begin : g_rule
    m_match_rule #(
      .W_DATA (W_DATA),
      .W_OFF  (W_OFF),
      .W_BUF  (W_BUF)
    ) u_rule (
      .clk_net    (clk_net),
      .rst_net    (rst_net),
      .cfg_we     (cfg_vld && (cfg_idx == W_IDX'(i))),
      .cfg_en     (cfg_en),
      .cfg_off    (cfg_off),
      .cfg_match  (cfg_match),
      .cfg_mask   (cfg_mask),
      .cfg_buffer (cfg_buffer),
      .beat_acc   (beat_acc),
      .in_sop     (in_sop),
      .cur_off    (cur_off),
      .off_sat    (cur_sat),
      .in_data    (in_data),
      .hit        (fin_hit[i]),
      .buffer     (rule_buf[i])
    );
  end

  // Scan high to low so the lowest set index is the last assignment.
  always_comb begin
    sel_buf = W_BUF'(DEFAULT_BUF);
    for (int i = N_RULES - 1; i >= 0; i--) begin
      if (fin_hit[i]) sel_buf = rule_buf[i];
    end
  end

  always_ff @(posedge clk_net or negedge rst_net) begin
    if (!rst_net) begin
      in_pkt_r  <= 1'b0;
      off_r     <= '0;
      off_sat_r <= 1'b0;
    end else if (beat_acc) begin
      in_pkt_r <= ~in_eop;
      if (in_sop) begin
        off_r     <= W_OFF'(1);
        off_sat_r <= 1'b0;
      end else if (off_r == OFF_MAX) begin
        // The beat at the last offset has been compared; beyond it nothing hits.
        off_sat_r <= 1'b1;
      end else begin
        off_r <= off_r + W_OFF'(1);
      end
    end
  end

  always_ff @(posedge clk_net or negedge rst_net) begin
    if (!rst_net) begin
      res_vld    <= 1'b0;
      res_hit    <= '0;
      res_buffer <= '0;
      err_ovf    <= 1'b0;
      err_proto  <= 1'b0;
    end else begin
      if (beat_bad) err_proto <= 1'b1;
      if (eop_done) begin
        if (!res_vld || res_rdy) begin
          res_vld    <= 1'b1;
          res_hit    <= fin_hit;
          res_buffer <= sel_buf;
        end else begin
          err_ovf <= 1'b1;
        end
      end else if (res_vld && res_rdy) begin
        res_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_m_match_classifier.sv
module tb_m_match_classifier;

  logic        clk_net;
  logic        rst_net;
  logic        cfg_vld;
  logic [1:0]  cfg_idx;
  logic        cfg_en;
  logic [7:0]  cfg_off;
  logic [63:0] cfg_match;
  logic [63:0] cfg_mask;
  logic [3:0]  cfg_buffer;
  logic        in_vld;
  logic        in_sop;
  logic        in_eop;
  logic [63:0] in_data;
  logic        res_vld;
  logic        res_rdy;
  logic [3:0]  res_hit;
  logic [3:0]  res_buffer;
  logic        err_ovf;
  logic        err_proto;

  int n_checks = 0;
  int n_pass   = 0;

  m_match_classifier #(
    .N_RULES     (4),
    .W_DATA      (64),
    .W_OFF       (8),
    .W_BUF       (4),
    .DEFAULT_BUF (9)
  ) dut (
    .clk_net    (clk_net),
    .rst_net    (rst_net),
    .cfg_vld    (cfg_vld),
    .cfg_idx    (cfg_idx),
    .cfg_en     (cfg_en),
    .cfg_off    (cfg_off),
    .cfg_match  (cfg_match),
    .cfg_mask   (cfg_mask),
    .cfg_buffer (cfg_buffer),
    .in_vld     (in_vld),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_data    (in_data),
    .res_vld    (res_vld),
    .res_rdy    (res_rdy),
    .res_hit    (res_hit),
    .res_buffer (res_buffer),
    .err_ovf    (err_ovf),
    .err_proto  (err_proto)
  );

  initial begin
    clk_net = 1'b0;
    forever #5 clk_net = ~clk_net;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cfg_rule(input logic [1:0] idx, input logic en, input logic [7:0] off,
                          input logic [63:0] match, input logic [63:0] mask, input logic [3:0] bufid);
    cfg_vld = 1'b1; cfg_idx = idx; cfg_en = en; cfg_off = off;
    cfg_match = match; cfg_mask = mask; cfg_buffer = bufid;
    @(posedge clk_net); #1;
    cfg_vld = 1'b0;
  endtask

  task automatic beat(input logic sop, input logic eop, input logic [63:0] d);
    in_vld = 1'b1; in_sop = sop; in_eop = eop; in_data = d;
    @(posedge clk_net); #1;
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
  endtask

  task automatic send4(input int n, input logic [63:0] w0, input logic [63:0] w1,
                       input logic [63:0] w2, input logic [63:0] w3);
    logic [63:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int k = 0; k < n; k++) beat(k == 0, k == n - 1, w[k]);
  endtask

  task automatic idle();
    @(posedge clk_net); #1;
  endtask

  initial begin
    rst_net = 1'b0; res_rdy = 1'b1;
    cfg_vld = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_off = '0;
    cfg_match = '0; cfg_mask = '0; cfg_buffer = '0;
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
    repeat (3) @(posedge clk_net);
    #1;
    check_val("rst_vld", res_vld, 0);
    check_val("rst_hit", res_hit, 0);
    check_val("rst_buf", res_buffer, 0);
    check_val("rst_ovf", err_ovf, 0);
    check_val("rst_proto", err_proto, 0);
    rst_net = 1'b1;
    idle();

    // Single rule, hit at offset 2, one-cycle latency
    cfg_rule(0, 1, 2, 64'hAB, 64'hFF, 3);
    beat(1, 0, 0); beat(0, 0, 0); beat(0, 0, 64'h12AB);
    check_val("t1_vld_pre", res_vld, 0);
    beat(0, 1, 0);
    check_val("t1_vld", res_vld, 1);
    check_val("t1_hit", res_hit, 4'b0001);
    check_val("t1_buf", res_buffer, 3);
    idle();
    check_val("t1_vld_drop", res_vld, 0);

    // Two rules hit, lowest index selects buffer
    cfg_rule(1, 1, 1, 64'h5500, 64'hFF00, 5);
    cfg_rule(2, 1, 3, 64'h77, 64'hFF, 7);
    send4(4, 0, 64'h55AA, 0, 64'h1177);
    check_val("t2_hit", res_hit, 4'b0110);
    check_val("t2_buf", res_buffer, 5);
    send4(4, 1, 2, 3, 4);
    check_val("t2_nohit", res_hit, 4'b0000);
    check_val("t2_defbuf", res_buffer, 9);

    // Single-beat packet then a clean following packet
    cfg_rule(3, 1, 0, 64'hDEAD, 64'hFFFF, 11);
    beat(1, 1, 64'hDEAD);
    check_val("t3_vld", res_vld, 1);
    check_val("t3_hit", res_hit, 4'b1000);
    check_val("t3_buf", res_buffer, 11);
    send4(4, 0, 64'h55AA, 0, 0);
    check_val("t3_clean_hit", res_hit, 4'b0010);
    check_val("t3_clean_buf", res_buffer, 5);

    // Zero mask matches any word; disabled rule never hits
    cfg_rule(3, 1, 0, 0, 0, 11);
    send4(2, 64'h1234, 0, 0, 0);
    check_val("mask0_hit", res_hit, 4'b1000);
    cfg_rule(3, 0, 0, 0, 0, 11);
    send4(2, 64'h1234, 0, 0, 0);
    check_val("dis_hit", res_hit, 4'b0000);
    check_val("dis_buf", res_buffer, 9);
    idle();

    // Overflow with result held, then back-to-back with no bubble
    res_rdy = 1'b0;
    send4(2, 0, 64'h55AA, 0, 0);
    check_val("ovf_a_vld", res_vld, 1);
    check_val("ovf_a_hit", res_hit, 4'b0010);
    check_val("ovf_pre", err_ovf, 0);
    send4(4, 0, 0, 0, 64'h77);
    check_val("ovf_hold_vld", res_vld, 1);
    check_val("ovf_hold_hit", res_hit, 4'b0010);
    check_val("ovf_hold_buf", res_buffer, 5);
    check_val("ovf_flag", err_ovf, 1);
    beat(1, 0, 0); beat(0, 0, 0);
    check_val("ovf_still_held", res_hit, 4'b0010);
    res_rdy = 1'b1;
    beat(0, 1, 64'hAB);
    check_val("b2b_c_vld", res_vld, 1);
    check_val("b2b_c_hit", res_hit, 4'b0001);
    check_val("b2b_c_buf", res_buffer, 3);
    beat(1, 1, 0);
    check_val("b2b_d_vld", res_vld, 1);
    check_val("b2b_d_hit", res_hit, 4'b0000);
    check_val("b2b_d_buf", res_buffer, 9);
    idle();
    check_val("b2b_drain", res_vld, 0);
    check_val("ovf_sticky", err_ovf, 1);

    // Protocol errors
    check_val("proto_pre", err_proto, 0);
    beat(0, 1, 64'h55AA);
    check_val("proto_nosop_vld", res_vld, 0);
    check_val("proto_nosop", err_proto, 1);
    beat(1, 0, 0); beat(0, 0, 64'h55AA);
    beat(1, 0, 0);
    check_val("proto_resop_vld", res_vld, 0);
    beat(0, 0, 0); beat(0, 0, 0); beat(0, 1, 64'h77);
    check_val("proto_resop_vld2", res_vld, 1);
    check_val("proto_resop_hit", res_hit, 4'b0100);
    check_val("proto_resop_buf", res_buffer, 7);
    idle();

    // Offset saturation: last offset still compares, beyond it nothing hits
    cfg_rule(0, 1, 255, 64'hC0DE, 64'hFFFF, 3);
    for (int k = 0; k < 256; k++) beat(k == 0, k == 255, (k == 255) ? 64'hC0DE : 64'h0);
    check_val("off_max_hit", res_hit, 4'b0001);
    check_val("off_max_buf", res_buffer, 3);
    for (int k = 0; k < 530; k++) beat(k == 0, k == 529, (k >= 256) ? 64'hC0DE : 64'h0);
    check_val("sat_hit", res_hit, 4'b0000);
    check_val("sat_buf", res_buffer, 9);
    idle();

    // Async reset mid-packet
    res_rdy = 1'b0;
    send4(2, 0, 64'h55AA, 0, 0);
    check_val("ar_pre_vld", res_vld, 1);
    beat(1, 0, 0); beat(0, 0, 0);
    #2 rst_net = 1'b0;
    #1;
    check_val("ar_vld", res_vld, 0);
    check_val("ar_hit", res_hit, 0);
    check_val("ar_buf", res_buffer, 0);
    check_val("ar_ovf", err_ovf, 0);
    check_val("ar_proto", err_proto, 0);
    #1 rst_net = 1'b1;
    idle();
    res_rdy = 1'b1;
    send4(4, 64'hDEAD, 64'h55AA, 64'hAB, 64'h77);
    check_val("ar_post_vld", res_vld, 1);
    check_val("ar_post_hit", res_hit, 4'b0000);
    check_val("ar_post_buf", res_buffer, 9);
    check_val("ar_post_proto", err_proto, 0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
